btn_debounce_pulse: RTL and testbench

- Pushbutton conditioner. Runs in the `clk` domain.
- Its `reset` input is driven by the synchronized, active-high reset produced by the board reset synchronizer.
- Brings an asynchronous mechanical button into the clock domain, rejects contact bounce with a stable-count FSM, and emits a debounced level plus one-cycle press/release strobes.
- Downstream control logic consumes the strobes.

---
 rtl/btn_debounce_pulse.sv | 78 +++++++
 tb/tb_btn_debounce_pulse.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_pulse.sv
// btn_debounce_pulse: synchronizes a bouncing button, debounces it, and emits a registered level plus press/release strobes
module btn_debounce_pulse #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_WIDTH = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_pulse,
  output logic btn_release
);
  typedef enum logic [1:0] {IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW} state_t;
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  state_t state, state_nx;
  logic [CNT_WIDTH-1:0] cnt, cnt_nx;
  logic sync1, sync2, level_nx, pulse_nx, release_nx;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      state <= IDLE_LOW;
      cnt <= '0;
      btn_level <= 1'b0;
      btn_pulse <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
      state <= state_nx;
      cnt <= cnt_nx;
      btn_level <= level_nx;
      btn_pulse <= pulse_nx;
      btn_release <= release_nx;
    end
  end
  // a WAIT state commits only after DEBOUNCE_CYCLES+1 consecutive agreeing samples of sync2
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    level_nx = btn_level;
    pulse_nx = 1'b0;
    release_nx = 1'b0;
    case (state)
      IDLE_LOW: begin
        state_nx = sync2 ? WAIT_HIGH : IDLE_LOW;
        cnt_nx = sync2 ? '0 : cnt;
      end
      WAIT_HIGH:
        if (!sync2) begin
          state_nx = IDLE_LOW;
          cnt_nx = '0;
        end else if (cnt == LAST) begin
          state_nx = IDLE_HIGH;
          level_nx = 1'b1;
          pulse_nx = 1'b1;
        end else cnt_nx = cnt + 1'b1;
      IDLE_HIGH: begin
        state_nx = sync2 ? IDLE_HIGH : WAIT_LOW;
        cnt_nx = sync2 ? cnt : '0;
      end
      WAIT_LOW:
        if (sync2) begin
          state_nx = IDLE_HIGH;
          cnt_nx = '0;
        end else if (cnt == LAST) begin
          state_nx = IDLE_LOW;
          level_nx = 1'b0;
          release_nx = 1'b1;
        end else cnt_nx = cnt + 1'b1;
      default: begin
        state_nx = IDLE_LOW;
        cnt_nx = '0;
        level_nx = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_btn_debounce_pulse.sv
// tb_btn_debounce_pulse: scenario tasks checked against a run-length reference model of the debouncer
module tb_btn_debounce_pulse;
  localparam int D = 4;
  logic clk = 1'b0, reset = 1'b1, btn_in = 1'b0;
  logic btn_level, btn_pulse, btn_release;
  int checks = 0, errors = 0;
  int dp = 0, dr = 0;
  logic [1:0] m_sync = 2'b00;
  int run = 0;
  logic m_level = 1'b0, m_pulse = 1'b0, m_release = 1'b0;
  btn_debounce_pulse #(.DEBOUNCE_CYCLES(D), .CNT_WIDTH(3)) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in),
    .btn_level(btn_level), .btn_pulse(btn_pulse), .btn_release(btn_release)
  );
  always #5 clk = ~clk;
  // model: a level is accepted once the twice-delayed input has disagreed with it for D+1 samples in a row
  always @(posedge clk) begin
    if (reset) begin
      m_sync = 2'b00;
      run = 0;
      m_level = 1'b0;
      m_pulse = 1'b0;
      m_release = 1'b0;
    end else begin
      m_pulse = 1'b0;
      m_release = 1'b0;
      run = (m_sync[1] != m_level) ? run + 1 : 0;
      if (run == D + 1) begin
        m_level = m_sync[1];
        m_pulse = m_level;
        m_release = !m_level;
        run = 0;
      end
      m_sync = {m_sync[0], btn_in};
    end
  end
  task automatic step(input logic b);
    btn_in = b;
    @(negedge clk);
    dp += int'(btn_pulse);
    dr += int'(btn_release);
  endtask
  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(i < 3);
      checks++;
      if ({btn_level, btn_pulse, btn_release} !== 3'b000) begin
        errors++;
        $display("FAIL reset cycle %0d: lvl/pls/rel=%b expected 000", i, {btn_level, btn_pulse, btn_release});
      end
    end
    reset = 1'b0;
  endtask
  task automatic test_clean_press();
    int p0;
    repeat (3) step(1'b0);
    p0 = dp;
    for (int i = 0; i < 20; i++) begin
      step(1'b1);
      checks++;
      if ({btn_level, btn_pulse, btn_release} !== {m_level, m_pulse, m_release}) begin
        errors++;
        $display("FAIL press cycle %0d: dut=%b model=%b", i, {btn_level, btn_pulse, btn_release}, {m_level, m_pulse, m_release});
      end
      if (i == 5 || i == 6 || i == 7) begin
        checks++;
        if ({btn_level, btn_pulse} !== ((i == 5) ? 2'b00 : (i == 6) ? 2'b11 : 2'b10)) begin
          errors++;
          $display("FAIL press latency edge k+%0d: lvl/pls=%b%b", i, btn_level, btn_pulse);
        end
      end
    end
    checks++;
    if (dp - p0 !== 1) begin
      errors++;
      $display("FAIL press count: got %0d expected 1", dp - p0);
    end
  endtask
  task automatic test_release();
    int p0, r0;
    p0 = dp;
    r0 = dr;
    for (int i = 0; i < 20; i++) begin
      step(1'b0);
      checks++;
      if ({btn_level, btn_pulse, btn_release} !== {m_level, m_pulse, m_release}) begin
        errors++;
        $display("FAIL release cycle %0d: dut=%b model=%b", i, {btn_level, btn_pulse, btn_release}, {m_level, m_pulse, m_release});
      end
      if (i == 5 || i == 6 || i == 7) begin
        checks++;
        if ({btn_level, btn_release} !== ((i == 5) ? 2'b10 : (i == 6) ? 2'b01 : 2'b00)) begin
          errors++;
          $display("FAIL release latency edge m+%0d: lvl/rel=%b%b", i, btn_level, btn_release);
        end
      end
    end
    checks++;
    if (dr - r0 !== 1 || dp != p0) begin
      errors++;
      $display("FAIL release count: releases %0d pulses %0d expected 1 and 0", dr - r0, dp - p0);
    end
  endtask
  task automatic test_bounce();
    bit pat[$];
    int p0, r0;
    pat = '{1,1,0,0,1,1,0,0,0,0,0,0,0,0,0,0,0,0,1,1,1,0,0,0,0,0,0,0,0,0,0};
    p0 = dp;
    r0 = dr;
    foreach (pat[i]) begin
      step(pat[i]);
      checks++;
      if ({btn_level, btn_pulse, btn_release} !== {m_level, m_pulse, m_release} || btn_level !== 1'b0) begin
        errors++;
        $display("FAIL bounce cycle %0d: dut=%b model=%b", i, {btn_level, btn_pulse, btn_release}, {m_level, m_pulse, m_release});
      end
    end
    checks++;
    if (dp != p0 || dr != r0) begin
      errors++;
      $display("FAIL bounce strobes: pulses %0d releases %0d expected 0", dp - p0, dr - r0);
    end
  endtask
  task automatic test_reset_mid_wait();
    for (int i = 0; i < 4; i++) step(1'b1);
    reset = 1'b1;
    step(1'b1);
    checks++;
    if ({btn_level, btn_pulse, btn_release} !== 3'b000) begin
      errors++;
      $display("FAIL midwait reset: lvl/pls/rel=%b expected 000", {btn_level, btn_pulse, btn_release});
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1);
      checks++;
      if (btn_pulse !== (i == 6) || btn_pulse !== m_pulse) begin
        errors++;
        $display("FAIL midwait pulse edge j+%0d: pulse=%b expected %b", i, btn_pulse, i == 6);
      end
    end
    for (int i = 0; i < 10; i++) step(1'b0);
    checks++;
    if (btn_level !== 1'b0 || m_level !== 1'b0) begin
      errors++;
      $display("FAIL midwait settle: level=%b expected 0", btn_level);
    end
  endtask
  task automatic test_repeated();
    int p0, r0;
    logic prev, last_press;
    p0 = dp;
    r0 = dr;
    prev = 1'b0;
    last_press = 1'b0;
    for (int n = 0; n < 60; n++) begin
      step((n % 20) < 10);
      checks++;
      if ({btn_level, btn_pulse, btn_release} !== {m_level, m_pulse, m_release}
          || (btn_pulse && btn_release) || (prev && (btn_pulse || btn_release))
          || (btn_pulse && last_press) || (btn_release && !last_press)) begin
        errors++;
        $display("FAIL repeat cycle %0d: dut=%b model=%b", n, {btn_level, btn_pulse, btn_release}, {m_level, m_pulse, m_release});
      end
      if (btn_pulse) last_press = 1'b1;
      if (btn_release) last_press = 1'b0;
      prev = btn_pulse || btn_release;
    end
    checks++;
    if (dp - p0 !== 3 || dr - r0 !== 3) begin
      errors++;
      $display("FAIL repeat count: pulses %0d releases %0d expected 3 and 3", dp - p0, dr - r0);
    end
  endtask
  task automatic test_random();
    int p0, r0, mp, mr, len;
    logic b, prev;
    p0 = dp;
    r0 = dr;
    mp = 0;
    mr = 0;
    prev = 1'b0;
    b = 1'b0;
    len = 0;
    for (int n = 0; n < 600; n++) begin
      if (len == 0) begin
        b = ~b;
        len = $urandom_range(1, 9);
      end
      len--;
      reset = ($urandom_range(0, 149) == 0);
      step(b);
      mp += int'(m_pulse);
      mr += int'(m_release);
      checks++;
      if ({btn_level, btn_pulse, btn_release} !== {m_level, m_pulse, m_release}
          || (btn_pulse && btn_release) || (prev && (btn_pulse || btn_release))) begin
        errors++;
        $display("FAIL random cycle %0d: dut=%b model=%b", n, {btn_level, btn_pulse, btn_release}, {m_level, m_pulse, m_release});
      end
      prev = btn_pulse || btn_release;
    end
    reset = 1'b0;
    checks++;
    if (dp - p0 !== mp || dr - r0 !== mr) begin
      errors++;
      $display("FAIL random count: pulses %0d/%0d releases %0d/%0d (dut/model)", dp - p0, mp, dr - r0, mr);
    end
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_reset_mid_wait();
    test_repeated();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
